// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared definitions for the decoder scan controller: FSM state encoding
// and the number of decoder lines being scanned.
package decoder_pkg;

    localparam int NUM_LINES = 4;
    localparam int IDX_W     = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } state_e;

endpackage

// File: rtl/decoder_scan_ctrl_if.sv
// Control/status bundle between a scan requester (master) and the
// decoder scan controller (slave).
interface decoder_scan_ctrl_if #(
    parameter int DWELL_W = 8
);
    logic               start_in;
    logic               stop_in;
    logic [DWELL_W-1:0] dwell_in;
    logic [3:0]         mask_in;
    logic [1:0]         sel_out;
    logic               en_out;
    logic               frame_out;
    logic               busy_out;

    modport master (
        output start_in, stop_in, dwell_in, mask_in,
        input  sel_out, en_out, frame_out, busy_out
    );

    modport slave (
        input  start_in, stop_in, dwell_in, mask_in,
        output sel_out, en_out, frame_out, busy_out
    );
endinterface

// File: rtl/decoder_scan_ctrl_scan_next_idx.sv
// Combinational search for the next unmasked line above cur, modulo the
// line count. nxt == cur when cur is the only unmasked line; wrap flags a
// non-increasing step; none flags that every line is masked.
module scan_next_idx
    import decoder_pkg::*;
(
    input  logic [IDX_W-1:0]     cur,
    input  logic [NUM_LINES-1:0] mask,
    output logic [IDX_W-1:0]     nxt,
    output logic                 wrap,
    output logic                 none
);
    logic             found;
    logic [IDX_W-1:0] idx;

    // Walk cur+1 .. cur+NUM_LINES and keep the first unmasked candidate.
    always_comb begin
        nxt   = cur;
        found = 1'b0;
        idx   = cur;
        for (int k = 1; k <= NUM_LINES; k++) begin
            idx = cur + IDX_W'(k);
            if (!found && !mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
    end

    assign none = (mask == '1);
    assign wrap = (nxt <= cur);
endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan controller driving a 2-to-4 line decoder: steps an enable through
// the unmasked lines, holding each for dwell+1 cycles.
// Optional build macro: DECODER_SCAN_BLANK_EN inserts BLANK_CYC enable-low
// cycles between lines; without it lines switch back-to-back.
module decoder_scan_ctrl
    import decoder_pkg::*;
#(
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 2
)(
    input  logic                clk_in,
    input  logic                rst_n_in,
    decoder_scan_ctrl_if.slave  bus
);
    state_e             state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic               en_q, en_d;
    logic               frame_q, frame_d;
    logic               stop_q, stop_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [3:0]         blank_q, blank_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [IDX_W-1:0]   pend_q, pend_d;
    logic               pwrap_q, pwrap_d;

    logic [IDX_W-1:0]   srch_cur;
    logic [IDX_W-1:0]   nxt;
    logic               wrap;
    logic               none;

    // From IDLE, searching above the top line yields the lowest unmasked one.
    assign srch_cur = (state_q == IDLE) ? IDX_W'(NUM_LINES - 1) : sel_q;

    scan_next_idx u_next (
        .cur  (srch_cur),
        .mask (bus.mask_in),
        .nxt  (nxt),
        .wrap (wrap),
        .none (none)
    );

    // Next-state logic; a pending stop is only honoured at a line boundary.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        en_d    = en_q;
        frame_d = 1'b0;
        stop_d  = stop_q;
        cnt_d   = cnt_q;
        blank_d = blank_q;
        dwell_d = dwell_q;
        pend_d  = pend_q;
        pwrap_d = pwrap_q;
        case (state_q)
            IDLE: begin
                en_d   = 1'b0;
                stop_d = 1'b0;
                if (bus.start_in && !bus.stop_in && !none) begin
                    state_d = ACTIVE;
                    sel_d   = nxt;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                    dwell_d = bus.dwell_in;
                end
            end
            ACTIVE: begin
                stop_d = stop_q | bus.stop_in;
                if (cnt_q == dwell_q) begin
                    if (stop_q || bus.stop_in || none) begin
                        state_d = IDLE;
                        en_d    = 1'b0;
                    end else begin
`ifdef DECODER_SCAN_BLANK_EN
                        state_d = BLANK;
                        en_d    = 1'b0;
                        blank_d = '0;
                        pend_d  = nxt;
                        pwrap_d = wrap;
`else
                        sel_d   = nxt;
                        frame_d = wrap;
                        cnt_d   = '0;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BLANK: begin
                stop_d = stop_q | bus.stop_in;
                if (blank_q == 4'(BLANK_CYC - 1)) begin
                    state_d = ACTIVE;
                    sel_d   = pend_q;
                    frame_d = pwrap_q;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                end else begin
                    blank_d = blank_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            sel_q   <= '0;
            en_q    <= 1'b0;
            frame_q <= 1'b0;
            stop_q  <= 1'b0;
            cnt_q   <= '0;
            blank_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            frame_q <= frame_d;
            stop_q  <= stop_d;
            cnt_q   <= cnt_d;
            blank_q <= blank_d;
        end
    end

    // Captured dwell and pending next line; always written before use.
    always_ff @(posedge clk_in) begin
        dwell_q <= dwell_d;
        pend_q  <= pend_d;
        pwrap_q <= pwrap_d;
    end

    assign bus.sel_out   = sel_q;
    assign bus.en_out    = en_q;
    assign bus.frame_out = frame_q;
    assign bus.busy_out  = (state_q != IDLE);
endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench for decoder_scan_ctrl: directed scans push expected
// lines (select, length, frame flag, preceding gap); a negedge monitor
// segments the enable stream into lines and checks them in order.
module tb_decoder_scan_ctrl;
    localparam int DW = 8;
    localparam int BC = 2;
`ifdef DECODER_SCAN_BLANK_EN
    localparam int GAP = BC;
`else
    localparam int GAP = 0;
`endif

    typedef struct {
        int sel;
        int len;
        int frame;
        int gap;
    } line_t;

    logic  clk = 1'b0;
    logic  rst_n;
    line_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    bit    in_seg = 1'b0;
    int    seg_sel = 0, seg_len = 0, seg_frame = 0, seg_gap = 0, gap_cnt = 0;

    decoder_scan_ctrl_if #(.DWELL_W(DW)) bus ();

    decoder_scan_ctrl #(.DWELL_W(DW), .BLANK_CYC(BC)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push(int sel, int len, int frame, int gap);
        line_t e;
        e = '{sel, len, frame, gap};
        exp_q.push_back(e);
    endtask

    task automatic close_seg();
        line_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_line: got sel %0d len %0d, required no line", seg_sel, seg_len);
        end else begin
            e = exp_q.pop_front();
            check("line_sel", seg_sel, e.sel);
            check("line_len", seg_len, e.len);
            check("line_frame", seg_frame, e.frame);
            if (e.gap >= 0) check("line_gap", seg_gap, e.gap);
        end
    endtask

    // Monitor: a new line starts on enable rise, select change or frame pulse.
    always @(negedge clk) begin
        if (bus.en_out) begin
            if (!in_seg || (int'(bus.sel_out) != seg_sel) || bus.frame_out) begin
                if (in_seg) close_seg();
                in_seg    = 1'b1;
                seg_sel   = int'(bus.sel_out);
                seg_len   = 1;
                seg_frame = int'(bus.frame_out);
                seg_gap   = gap_cnt;
                gap_cnt   = 0;
            end else begin
                seg_len++;
            end
        end else begin
            if (in_seg) begin
                close_seg();
                in_seg = 1'b0;
            end
            if (gap_cnt < 1000) gap_cnt++;
        end
    end

    task automatic start_pulse(int mask, int dwell);
        @(negedge clk);
        bus.mask_in  = 4'(mask);
        bus.dwell_in = DW'(dwell);
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
    endtask

    task automatic wait_frames(int n);
        int seen = 0;
        for (int i = 0; i < 400 && seen < n; i++) begin
            @(negedge clk);
            if (bus.frame_out) seen++;
        end
        check("frame_wait", seen, n);
    endtask

    task automatic pulse_stop();
        bus.stop_in = 1'b1;
        @(negedge clk);
        bus.stop_in = 1'b0;
    endtask

    task automatic wait_idle(int sel_exp);
        for (int i = 0; i < 400 && bus.busy_out; i++) @(negedge clk);
        check("idle_busy", int'(bus.busy_out), 0);
        check("idle_en", int'(bus.en_out), 0);
        check("idle_sel", int'(bus.sel_out), sel_exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_in = 1'b0;
        bus.stop_in  = 1'b0;
        bus.mask_in  = 4'h0;
        bus.dwell_in = '0;
        rst_n        = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sel", int'(bus.sel_out), 0);
        check("rst_en", int'(bus.en_out), 0);
        check("rst_frame", int'(bus.frame_out), 0);
        check("rst_busy", int'(bus.busy_out), 0);
        rst_n = 1'b1;

        // Full scan, dwell 3, stop during the wrapped line 0.
        push(0, 4, 0, -1); push(1, 4, 0, GAP); push(2, 4, 0, GAP);
        push(3, 4, 0, GAP); push(0, 4, 1, GAP);
        start_pulse(0, 3);
        wait_frames(1);
        pulse_stop();
        wait_idle(0);

        // Lines 0 and 2 only, dwell 0; stop on the second wrap.
        push(0, 1, 0, -1); push(2, 1, 0, GAP); push(0, 1, 1, GAP);
        push(2, 1, 0, GAP); push(0, 1, 1, GAP);
        start_pulse(4'b1010, 0);
        wait_frames(2);
        pulse_stop();
        wait_idle(0);

        // Stop in cycle 1 of a dwell of 5 on line 1 lets the line finish.
        push(1, 6, 0, -1);
        start_pulse(4'b0001, 5);
        @(negedge clk);
        pulse_stop();
        wait_idle(1);
        repeat (3) @(negedge clk);
        check("hold_sel", int'(bus.sel_out), 1);

        // All lines masked: start is refused.
        start_pulse(4'hF, 2);
        for (int i = 0; i < 3; i++) begin
            check("allmask_busy", int'(bus.busy_out), 0);
            check("allmask_en", int'(bus.en_out), 0);
            @(negedge clk);
        end
        check("allmask_sel", int'(bus.sel_out), 1);

        // Start and stop together: stays idle.
        bus.mask_in  = 4'h0;
        bus.start_in = 1'b1;
        bus.stop_in  = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        bus.stop_in  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("startstop_busy", int'(bus.busy_out), 0);
            @(negedge clk);
        end

        // Reset in the middle of a dwell on line 2.
        push(2, 3, 0, -1);
        start_pulse(4'b0011, 7);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_en", int'(bus.en_out), 0);
        check("midrst_sel", int'(bus.sel_out), 0);
        check("midrst_busy", int'(bus.busy_out), 0);
        check("midrst_frame", int'(bus.frame_out), 0);
        rst_n = 1'b1;

        // Full scan, dwell 1.
        push(0, 2, 0, -1); push(1, 2, 0, GAP); push(2, 2, 0, GAP);
        push(3, 2, 0, GAP); push(0, 2, 1, GAP);
        start_pulse(0, 1);
        wait_frames(1);
        pulse_stop();
        wait_idle(0);

        // Single unmasked line: every advance is a wrap.
        push(2, 2, 0, -1); push(2, 2, 1, GAP); push(2, 2, 1, GAP);
        start_pulse(4'b1011, 1);
        wait_frames(2);
        pulse_stop();
        wait_idle(2);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/decoder_scan_ctrl.md
DECODER_SCAN_CTRL -- requirements
Module: decoder_scan_ctrl

Interface
REQ-001 Parameter DWELL_W, default 8, width of the per-line dwell count.
REQ-002 Parameter BLANK_CYC, default 2, range 1..15, number of blanking cycles between lines when blanking is compiled in.
REQ-003 Port clk_in, input, 1, single clock; all logic is synchronous to its rising edge.
REQ-004 Port rst_n_in, input, 1, reset; the block SHALL use one clock and a synchronous, active-low reset.
REQ-005 Port start_in, input, 1, request to begin scanning; sampled every cycle.
REQ-006 Port stop_in, input, 1, request to end scanning; sampled every cycle.
REQ-007 Port dwell_in, input, DWELL_W, active time per line minus one.
REQ-008 Port mask_in, input, 4, bit i = 1 means line i is skipped.
REQ-009 Port sel_out, output, 2, registered line index for the downstream 2-to-4 decoder sel_in.
REQ-010 Port en_out, output, 1, registered enable for the downstream decoder en_in.
REQ-011 Port frame_out, output, 1, one-cycle pulse on scan wrap-around.
REQ-012 Port busy_out, output, 1, high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ACTIVE and BLANK.
REQ-014 In IDLE: en_out=0, sel_out holds its last value, and busy_out=0.
REQ-015 IDLE->ACTIVE when start_in=1, stop_in=0 and mask_in!=4'hF; sel_out loads the lowest unmasked index and en_out=1 from the next edge (1-cycle latency).
REQ-016 start_in SHALL be ignored outside IDLE; simultaneous start_in and stop_in in IDLE SHALL leave the block in IDLE.
REQ-017 dwell_in SHALL be captured on ACTIVE entry; en_out stays 1 for exactly dwell_in+1 cycles per line, with dwell_in=0 giving 1 cycle.
REQ-018 At dwell end the next line SHALL be the next unmasked index above sel_out, searched modulo 4 using mask_in sampled that cycle.
REQ-019 frame_out=1 for one cycle, coincident with the new sel_out, whenever the next index is <= the current index; with a single unmasked line it pulses every advance.
REQ-020 If mask_in=4'hF at an advance point, or stop_in has been seen since ACTIVE entry, the block SHALL go to IDLE instead of advancing: en_out=0 next cycle, sel_out unchanged, frame_out=0.
REQ-021 stop_in SHALL never truncate a dwell; it is latched and acted on at the next advance point.
REQ-022 BLANK: en_out=0 for BLANK_CYC cycles, then ACTIVE on the next line; sel_out SHALL change only on the BLANK->ACTIVE edge so the decoder never sees a select change while enabled.

Reset
REQ-023 With rst_n_in=0 at a rising edge: state=IDLE, sel_out=2'b00, en_out=0, frame_out=0, busy_out=0, and the stop latch and counters are cleared.
REQ-024 Reset mid-dwell or mid-blank SHALL take effect at that edge with no completion of the line.

Configuration
REQ-025 Macro DECODER_SCAN_BLANK_EN: when defined, BLANK SHALL be used per REQ-022; when undefined, BLANK SHALL be unreachable, ACTIVE advances directly to the next line, en_out stays 1 across the boundary, and sel_out changes on the same edge.

Structure
REQ-026 Shared package decoder_pkg SHALL hold the state encoding (IDLE=2'd0, ACTIVE=2'd1, BLANK=2'd2) and the constant NUM_LINES=4.
REQ-027 The next-unmasked-index search SHALL be a combinational sub-module named scan_next_idx (inputs cur, mask; outputs nxt, wrap, none).

Verification
REQ-028 Reset, then start pulse with mask=0, dwell=3 and blanking on -> sel sequence 0,1,2,3,0 with en high 4 cycles each, low 2 cycles between lines, and frame_out pulsing at the 3->0 transition.
REQ-029 mask=4'b1010, dwell=0 -> sel alternates 0,2, with a frame pulse on each 2->0.
REQ-030 stop_in pulsed in cycle 1 of a dwell of 5 -> full 6-cycle dwell completes, then en=0 and busy=0, with sel unchanged.
REQ-031 start_in with mask=4'hF -> the block stays IDLE and busy=0; start and stop asserted together -> the block stays IDLE.
REQ-032 rst_n_in low mid-dwell on sel=2 -> the next cycle shows en=0, sel=0 and busy=0.
REQ-033 Build without DECODER_SCAN_BLANK_EN, mask=0, dwell=1 -> en continuously 1 and sel changes every 2 cycles.
